clock_divider_select_multi: RTL and testbench

//   Parametrised successor to the single-pair clock divider/selector. Generates NUM_CH independent

---
 rtl/clock_divider_select_multi.sv | 126 ++++++++++++
 tb/tb_clock_divider_select_multi.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_select_multi.sv
// NUM_CH independent runtime-programmable clock dividers with a glitch-free
// channel selector and enable gate driving one registered output clock.
module clock_divider_select_multi #(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 0,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic                    en_i,
  output logic [NUM_CH-1:0]       div_clk_o,
  output logic                    clk_o,
  output logic                    busy_o
);

  localparam int SEL_N = 1 << SEL_W;
  // One bit per encodable select value; set only for channels that exist.
  localparam logic [SEL_N-1:0] SEL_VALID = SEL_N'((64'd1 << NUM_CH) - 64'd1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PARK,
    ST_WAIT
  } state_t;

  logic [DIV_W-1:0]  cnt    [NUM_CH];
  logic [DIV_W-1:0]  shadow [NUM_CH];
  logic [NUM_CH-1:0] div_clk_q;

  state_t            state;
  logic [SEL_W-1:0]  cur_sel;
  logic [SEL_W-1:0]  tgt_sel;
  logic              en_q;
  logic              clk_q;
  logic              busy_q;

  logic              cur_clk;
  logic              tgt_clk;
  logic              sel_ok;

  assign cur_clk = div_clk_q[cur_sel];
  assign tgt_clk = div_clk_q[tgt_sel];
  assign sel_ok  = SEL_VALID[sel_i];

  // Shadow divisor reloads only on the falling toggle, so every
  // fall-to-fall period is built from a single divisor value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        cnt[k]    <= '0;
        shadow[k] <= DIV_W'(DIV_RST);
      end
      div_clk_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (cnt[k] >= shadow[k]) begin
          cnt[k]       <= '0;
          div_clk_q[k] <= ~div_clk_q[k];
          if (div_clk_q[k]) begin
            shadow[k] <= div_i[k*DIV_W +: DIV_W];
          end
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
    end else if (!cur_clk) begin
      en_q <= en_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      cur_sel <= '0;
      tgt_sel <= '0;
      clk_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          clk_q <= en_q & cur_clk;
          if (sel_i != cur_sel && sel_ok) begin
            tgt_sel <= sel_i;
            state   <= ST_PARK;
            busy_q  <= 1'b1;
          end
        end
        ST_PARK: begin
          if (!cur_clk) begin
            clk_q <= 1'b0;
            state <= ST_WAIT;
          end else begin
            clk_q <= en_q & cur_clk;
          end
        end
        ST_WAIT: begin
          clk_q <= 1'b0;
          if (!tgt_clk) begin
            cur_sel <= tgt_sel;
            state   <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          clk_q  <= 1'b0;
          state  <= ST_RUN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign div_clk_o = div_clk_q;
  assign clk_o     = clk_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_clock_divider_select_multi.sv
// Directed bench for clock_divider_select_multi (3 channels): a cycle model
// pushes expected outputs to a queue each cycle; they are popped after the edge.
module tb_clock_divider_select_multi;
  localparam int NUM_CH = 3;
  localparam int DIV_W  = 4;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [SEL_W-1:0]        sel_i;
  logic                    en_i;
  logic [NUM_CH-1:0]       div_clk_o;
  logic                    clk_o;
  logic                    busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [NUM_CH-1:0] dc;
    logic              co;
    logic              bz;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  logic [NUM_CH-1:0] m_dc;
  int                m_left [NUM_CH];
  int                m_sh   [NUM_CH];
  int                m_state;
  int                m_cur, m_tgt;
  logic              m_en, m_clk, m_busy;

  clock_divider_select_multi #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W),
    .DIV_RST(0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_i    (div_i),
    .sel_i    (sel_i),
    .en_i     (en_i),
    .div_clk_o(div_clk_o),
    .clk_o    (clk_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_sh[k]   = 0;
      m_left[k] = 1;
    end
    m_state = 0; m_cur = 0; m_tgt = 0;
    m_en = 1'b0; m_clk = 1'b0; m_busy = 1'b0;
  endtask

  // Advance the model one clk edge using the inputs currently driven.
  task automatic model_step();
    logic [NUM_CH-1:0] od;
    logic              new_en;
    if (!rst_n) begin
      model_reset();
      return;
    end
    od = m_dc;
    for (int k = 0; k < NUM_CH; k++) begin
      if (m_left[k] == 1) begin
        m_dc[k] = ~od[k];
        if (od[k]) m_sh[k] = int'(div_i[k*DIV_W +: DIV_W]);
        m_left[k] = m_sh[k] + 1;
      end else begin
        m_left[k]--;
      end
    end
    new_en = od[m_cur] ? m_en : en_i;
    case (m_state)
      0: begin
        m_clk = m_en & od[m_cur];
        if (int'(sel_i) != m_cur && int'(sel_i) < NUM_CH) begin
          m_tgt = int'(sel_i); m_state = 1; m_busy = 1'b1;
        end
      end
      1: begin
        if (!od[m_cur]) begin m_clk = 1'b0; m_state = 2; end
        else m_clk = m_en & od[m_cur];
      end
      default: begin
        m_clk = 1'b0;
        if (!od[m_tgt]) begin m_cur = m_tgt; m_state = 0; m_busy = 1'b0; end
      end
    endcase
    m_en = new_en;
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    exp_q.push_back('{m_dc, m_clk, m_busy});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("div_clk_o", 32'(div_clk_o), 32'(e.dc));
    chk("clk_o", 32'(clk_o), 32'(e.co));
    chk("busy_o", 32'(busy_o), 32'(e.bz));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic logic sig_val(input int s);
    return (s == NUM_CH) ? clk_o : div_clk_o[s];
  endfunction

  // Length in cycles of the next complete phase at level lvl (s==NUM_CH is clk_o).
  task automatic measure(input int s, input logic lvl, output int len);
    int t = 0;
    while (sig_val(s) == lvl && t < 40) begin cycle(); t++; end
    while (sig_val(s) != lvl && t < 80) begin cycle(); t++; end
    len = 0;
    while (sig_val(s) == lvl && t < 120) begin cycle(); t++; len++; end
  endtask

  task automatic set_div(input int ch, input int val);
    div_i[ch*DIV_W +: DIV_W] = DIV_W'(val);
  endtask

  initial begin
    int len;
    int t;
    // 1: reset with random inputs, then release with all divisors 0
    rst_n = 1'b0;
    div_i = NUM_CH*DIV_W'($urandom);
    sel_i = SEL_W'($urandom);
    en_i  = 1'($urandom);
    #1;
    model_reset();
    chk("rst_div_clk", 32'(div_clk_o), 32'(m_dc));
    chk("rst_clk_o", 32'(clk_o), 32'(m_clk));
    chk("rst_busy", 32'(busy_o), 32'(m_busy));
    for (int i = 0; i < 4; i++) begin
      div_i = NUM_CH*DIV_W'($urandom);
      sel_i = SEL_W'($urandom);
      en_i  = 1'($urandom);
      cycle();
    end
    div_i = '0; sel_i = '0; en_i = 1'b0;
    rst_n = 1'b1;
    run(4);

    // 2: ch1 divisor 3 selected and enabled
    set_div(0, 2); set_div(1, 3); set_div(2, 3);
    en_i = 1'b1; sel_i = 2'd1;
    run(24);
    measure(1, 1'b1, len); chk("ch1_high_len", 32'(len), 32'd4);
    measure(1, 1'b0, len); chk("ch1_low_len", 32'(len), 32'd4);
    measure(NUM_CH, 1'b1, len); chk("clk_o_high_len", 32'(len), 32'd4);

    // 3: ch0 divisor 2 -> 5 applied while ch0 is high
    measure(0, 1'b1, len); chk("ch0_high_len_div2", 32'(len), 32'd3);
    t = 0;
    while (div_clk_o[0] !== 1'b1 && t < 20) begin cycle(); t++; end
    chk("ch0_wait_high", 32'(div_clk_o[0]), 32'd1);
    set_div(0, 5);
    measure(0, 1'b0, len); chk("ch0_low_len_div5", 32'(len), 32'd6);
    measure(0, 1'b1, len); chk("ch0_high_len_div5", 32'(len), 32'd6);

    // 4: back to ch0 with divisor 0, then switch to ch2
    set_div(0, 0); sel_i = 2'd0;
    t = 0;
    while (!(m_state == 0 && m_cur == 0) && t < 40) begin cycle(); t++; end
    chk("sw_to_ch0_busy", 32'(busy_o), 32'd0);
    run(6);
    sel_i = 2'd2;
    cycle();
    chk("sw_to_ch2_busy", 32'(busy_o), 32'd1);
    t = 0;
    while (busy_o === 1'b1 && t < 30) begin cycle(); t++; end
    chk("sw_to_ch2_done", 32'(busy_o), 32'd0);
    run(16);

    // 5: enable dropped mid-high, reasserted mid-high
    t = 0;
    while (m_clk !== 1'b1 && t < 20) begin cycle(); t++; end
    chk("en_wait_clk_high", 32'(clk_o), 32'd1);
    en_i = 1'b0;
    run(20);
    t = 0;
    while (!(m_dc[2] && !m_clk && m_left[2] > 1) && t < 20) begin cycle(); t++; end
    chk("en_wait_ch2_high", 32'(div_clk_o[2]), 32'd1);
    en_i = 1'b1;
    run(20);

    // 6: out-of-range select ignored; reset while waiting on a switch
    sel_i = 2'd3;
    run(12);
    chk("oor_busy", 32'(busy_o), 32'd0);
    sel_i = 2'd1;
    t = 0;
    while (m_state != 2 && t < 30) begin cycle(); t++; end
    chk("reach_wait_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_div_clk", 32'(div_clk_o), 32'(m_dc));
    chk("midrst_clk_o", 32'(clk_o), 32'(m_clk));
    chk("midrst_busy", 32'(busy_o), 32'(m_busy));
    run(3);
    sel_i = 2'd0;
    rst_n = 1'b1;
    run(24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
